// File: rtl/mux_2_arbiter.sv
// Two-source valid/ready stream merge with round-robin arbitration, packet
// locking and a registered output word tagged with its source index.
module mux_2_arbiter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] data0,
   input  logic         valid0,
   input  logic         last0,
   output logic         ready0,
   input  logic [N-1:0] data1,
   input  logic         valid1,
   input  logic         last1,
   output logic         ready1,
   output logic [N-1:0] result,
   output logic         result_valid,
   output logic         result_last,
   output logic         result_sel,
   input  logic         result_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t       state_r;
   state_t       state_s;
   logic         prio_r;
   logic         prio_s;
   logic [N-1:0] result_r;
   logic         result_valid_r;
   logic         result_last_r;
   logic         result_sel_r;
   logic         out_free_s;
   logic         ready0_s;
   logic         ready1_s;
   logic         xfer0_s;
   logic         xfer1_s;

   // Ready of the granted source: output slot empty or being drained now
   always_comb begin
      out_free_s = !result_valid_r || result_ready;
      ready0_s   = 1'b0;
      ready1_s   = 1'b0;
      case (state_r)
         GNT0: ready0_s = out_free_s;
         GNT1: ready1_s = out_free_s;
         default: begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
         end
      endcase
      xfer0_s = valid0 && ready0_s;
      xfer1_s = valid1 && ready1_s;
   end

   // Arbitration and packet lock: grant released only by a last-word transfer
   always_comb begin
      state_s = state_r;
      prio_s  = prio_r;
      case (state_r)
         IDLE: begin
            if (valid0 && valid1) begin
               state_s = prio_r ? GNT1 : GNT0;
            end else if (valid0) begin
               state_s = GNT0;
            end else if (valid1) begin
               state_s = GNT1;
            end else begin
               state_s = IDLE;
            end
         end
         GNT0: begin
            if (xfer0_s && last0) begin
               state_s = IDLE;
               prio_s  = 1'b1;
            end else begin
               state_s = GNT0;
            end
         end
         GNT1: begin
            if (xfer1_s && last1) begin
               state_s = IDLE;
               prio_s  = 1'b0;
            end else begin
               state_s = GNT1;
            end
         end
         default: begin
            state_s = IDLE;
            prio_s  = prio_r;
         end
      endcase
   end

   // FSM state and priority pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         prio_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         prio_r  <= prio_s;
      end
   end

   // Output word register; a drained slot keeps its payload, only valid drops
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r       <= {N{1'b0}};
         result_valid_r <= 1'b0;
         result_last_r  <= 1'b0;
         result_sel_r   <= 1'b0;
      end else if (xfer0_s) begin
         result_r       <= data0;
         result_valid_r <= 1'b1;
         result_last_r  <= last0;
         result_sel_r   <= 1'b0;
      end else if (xfer1_s) begin
         result_r       <= data1;
         result_valid_r <= 1'b1;
         result_last_r  <= last1;
         result_sel_r   <= 1'b1;
      end else if (result_ready) begin
         result_valid_r <= 1'b0;
      end
   end

   assign ready0       = ready0_s;
   assign ready1       = ready1_s;
   assign result       = result_r;
   assign result_valid = result_valid_r;
   assign result_last  = result_last_r;
   assign result_sel   = result_sel_r;

endmodule

// File: tb/tb_mux_2_arbiter.sv
// Scoreboard bench for mux_2_arbiter: directed scenarios plus randomized
// saturated traffic checked against a packet-level round-robin model.
module tb_mux_2_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dat = 16'h0000;
   logic [1:0]  vld = 2'b00;
   logic [1:0]  lst = 2'b00;
   logic [1:0]  rdy;
   logic [7:0]  result;
   logic        result_valid;
   logic        result_last;
   logic        result_sel;
   logic        result_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [8:0] wq0[$];
   logic [8:0] wq1[$];
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   mux_2_arbiter #(.N(8)) dut (
      .clk(clk), .rst(rst),
      .data0(dat[7:0]), .valid0(vld[0]), .last0(lst[0]), .ready0(rdy[0]),
      .data1(dat[15:8]), .valid1(vld[1]), .last1(lst[1]), .ready1(rdy[1]),
      .result(result), .result_valid(result_valid), .result_last(result_last),
      .result_sel(result_sel), .result_ready(result_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor plus backpressure properties, sampled on negedge
   task automatic monitor();
      logic       hold = 1'b0;
      logic [9:0] held = 10'h000;
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else begin
            if (hold) chk("hold_stable", 32'({result_valid, result_sel, result_last, result}), 32'({1'b1, held}));
            if (result_valid && !result_ready) chk("bp_ready_low", 32'(rdy), 32'd0);
            if (rdy == 2'b11) chk("one_grant", 32'(rdy), 32'd1);
            if (result_valid && result_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", 32'({result_sel, result_last, result}), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_word", 32'({result_sel, result_last, result}), 32'(e));
               end
            end
            hold = result_valid && !result_ready;
            held = {result_sel, result_last, result};
         end
      end
   endtask

   task automatic wait_ready(input int s);
      int g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!rdy[s] && g < 300);
      if (!rdy[s]) chk("ready_timeout", 32'(s), 32'hFFFF_FFFF);
   endtask

   // Source model: holds word until accepted, may drop valid inside a packet
   task automatic drive(input int s, input int gap_pct);
      logic [8:0] w;
      logic       first = 1'b1;
      forever begin
         if (s == 0) begin
            if (wq0.size() == 0) break;
            w = wq0.pop_front();
         end else begin
            if (wq1.size() == 0) break;
            w = wq1.pop_front();
         end
         if (!first && gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
            vld[s] = 1'b0;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
         end
         dat[s*8 +: 8] = w[7:0];
         lst[s] = w[8];
         vld[s] = 1'b1;
         wait_ready(s);
         @(posedge clk);
         #1;
         first = w[8];
      end
      vld[s] = 1'b0;
      lst[s] = 1'b0;
   endtask

   task automatic push_word(input int s, input logic last, input logic [7:0] d);
      if (s == 0) wq0.push_back({last, d});
      else wq1.push_back({last, d});
      exp_q.push_back({s[0], last, d});
   endtask

   // Packet-level model: with both sources always requesting, packets alternate
   task automatic gen_alt(input logic p, input int n0, input int n1);
      int   c0 = n0;
      int   c1 = n1;
      int   len;
      logic cur = p;
      while (c0 + c1 > 0) begin
         if (c0 == 0) cur = 1'b1;
         else if (c1 == 0) cur = 1'b0;
         len = $urandom_range(4, 1);
         for (int i = 0; i < len; i++) push_word(int'(cur), (i == len - 1), 8'($urandom));
         if (cur) c1--;
         else c0--;
         cur = ~cur;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      vld = 2'b00;
      lst = 2'b00;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int g = 0;
      while (exp_q.size() > 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      repeat (3) @(negedge clk);
      chk(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int  cnt;
      int  g;
      bit  rand_run;
      fork
         monitor();
      join_none

      // reset state and idle hold
      do_reset();
      @(negedge clk);
      chk("reset_state", 32'({result_valid, result_last, result_sel, result, rdy}), 32'd0);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (result_valid || rdy != 2'b00 || result != 8'h00) cnt++;
      end
      chk("idle_hold", 32'(cnt), 32'd0);

      // single word from source 0
      @(posedge clk);
      #1;
      dat[7:0] = 8'hA5;
      lst[0] = 1'b1;
      vld[0] = 1'b1;
      exp_q.push_back({1'b0, 1'b1, 8'hA5});
      @(negedge clk);
      chk("sw_ready_idle", 32'(rdy[0]), 32'd0);
      @(negedge clk);
      chk("sw_ready_gnt", 32'(rdy[0]), 32'd1);
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      lst[0] = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (result_valid) cnt++;
      end
      chk("sw_valid_cycles", 32'(cnt), 32'd1);

      // priority now favours source 1 on a tie
      push_word(1, 1'b1, 8'hB1);
      push_word(0, 1'b1, 8'hB0);
      fork
         drive(0, 0);
         drive(1, 0);
      join
      drain("prio_drain");

      // tie and round-robin from reset
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_word(0, 1'b1, 8'h10 + 8'(i));
         push_word(1, 1'b1, 8'h20 + 8'(i));
      end
      fork
         drive(0, 0);
         drive(1, 0);
      join
      drain("rr_drain");

      // packet lock: source 1 owns the output until 0x33
      do_reset();
      @(posedge clk);
      #1;
      push_word(1, 1'b0, 8'h31);
      push_word(1, 1'b0, 8'h32);
      push_word(1, 1'b1, 8'h33);
      push_word(0, 1'b1, 8'h40);
      fork
         drive(1, 0);
         begin
            @(posedge clk);
            #1;
            drive(0, 0);
         end
         begin
            g = 0;
            do begin
               @(negedge clk);
               g++;
            end while (!rdy[0] && g < 100);
            chk("lock_release", 32'({rdy[0], vld[1], wq1.size() == 0}), 32'b101);
         end
      join
      drain("lock_drain");

      // backpressure during a source 0 packet
      do_reset();
      for (int i = 0; i < 4; i++) push_word(0, (i == 3), 8'h71 + 8'(i));
      fork
         drive(0, 0);
         begin
            g = 0;
            do begin
               @(negedge clk);
               g++;
            end while (!result_valid && g < 100);
            @(posedge clk);
            #1;
            result_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            result_ready = 1'b1;
         end
      join
      drain("bp_drain");

      // reset after word 2 of a 4-word packet drops the buffered word
      do_reset();
      @(posedge clk);
      #1;
      dat[7:0] = 8'h51;
      lst[0] = 1'b0;
      vld[0] = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 8'h51});
      wait_ready(0);
      @(posedge clk);
      #1;
      dat[7:0] = 8'h52;
      wait_ready(0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      vld[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_state", 32'({result_valid, rdy}), 32'd0);
      push_word(1, 1'b0, 8'h61);
      push_word(1, 1'b0, 8'h62);
      push_word(1, 1'b1, 8'h63);
      drive(1, 0);
      drain("midrst_drain");

      // randomized saturated traffic with random gaps and backpressure
      do_reset();
      gen_alt(1'b0, 12, 12);
      rand_run = 1'b1;
      fork
         begin
            fork
               drive(0, 30);
               drive(1, 30);
            join
            rand_run = 1'b0;
         end
         begin
            while (rand_run) begin
               @(posedge clk);
               #1;
               result_ready = ($urandom_range(3, 0) != 0);
            end
            result_ready = 1'b1;
         end
      join
      drain("rand_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
